// File: rtl/i2c_slave_axis.sv
`default_nettype none
//============================================================================
// Module   : i2c_slave_axis
// Brief    : I2C target; master writes leave on m_axis, master reads come from s_axis.
// Revision : 1.0 - initial release
//============================================================================
module i2c_slave_axis #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         DATA_WIDTH  = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy_o
);

  localparam logic [3:0] c_LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] c_BYTE_BITS = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_MACK, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_prev, r_sda_prev;
  logic                   w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]  r_rx, w_rx_nxt, r_tx, w_tx_nxt, w_byte;
  logic [DATA_WIDTH-1:0]  r_m_tdata, w_m_tdata_nxt;
  logic                   r_ack, w_ack_nxt, r_phase, w_phase_nxt, r_rw, w_rw_nxt;
  logic                   r_sda_oe, w_sda_oe_nxt, r_busy, w_busy_nxt;
  logic                   r_m_tvalid, w_m_tvalid_nxt, r_s_tready, w_s_tready_nxt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_prev;
  assign w_fall  = ~w_scl & r_scl_prev;
  assign w_start = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte  = {r_rx[DATA_WIDTH-2:0], w_sda};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_ack      <= 1'b0;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_s_tready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_rx       <= w_rx_nxt;
      r_tx       <= w_tx_nxt;
      r_ack      <= w_ack_nxt;
      r_phase    <= w_phase_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_m_tdata  <= w_m_tdata_nxt;
      r_m_tvalid <= w_m_tvalid_nxt;
      r_s_tready <= w_s_tready_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_nxt       = r_rx;
    w_tx_nxt       = r_tx;
    w_ack_nxt      = r_ack;
    w_phase_nxt    = r_phase;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_m_tdata_nxt  = r_m_tdata;
    w_m_tvalid_nxt = r_m_tvalid & ~m_axis_tready;
    w_s_tready_nxt = 1'b0;

    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_bit_cnt_nxt = '0;
      w_phase_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_sda_oe_nxt  = 1'b0;
      w_bit_cnt_nxt = '0;
      w_phase_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_rise) begin
            w_rx_nxt = w_byte;
            if (r_bit_cnt == c_LAST_BIT) begin
              w_bit_cnt_nxt = '0;
              w_phase_nxt   = 1'b0;
              if (w_byte[DATA_WIDTH-1:1] != SLAVE_ADDR) begin
                w_state_nxt = S_WAIT_STOP;
              end else begin
                w_rw_nxt    = w_byte[0];
                w_state_nxt = S_ADDR_ACK;
                if (!w_byte[0]) begin
                  w_ack_nxt = 1'b1;
                end else if (s_axis_tvalid) begin
                  w_tx_nxt       = s_axis_tdata;
                  w_s_tready_nxt = 1'b1;
                  w_ack_nxt      = 1'b1;
                end else begin
                  w_ack_nxt = 1'b0;
                end
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end

        // phase 0: drive the ack on the first fall; phase 1: the next fall ends the slot
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (w_fall) begin
            if (!r_phase) begin
              w_phase_nxt  = 1'b1;
              w_sda_oe_nxt = r_ack;
              if (r_ack) w_busy_nxt = 1'b1;
            end else begin
              w_phase_nxt   = 1'b0;
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
              if (!r_ack) begin
                w_state_nxt = S_WAIT_STOP;
              end else if (r_state == S_WRITE_ACK || !r_rw) begin
                w_state_nxt = S_WRITE;
              end else begin
                w_state_nxt   = S_READ;
                w_sda_oe_nxt  = ~r_tx[DATA_WIDTH-1];
                w_tx_nxt      = {r_tx[DATA_WIDTH-2:0], 1'b0};
                w_bit_cnt_nxt = 4'd1;
              end
            end
          end
        end

        S_WRITE: begin
          if (w_rise) begin
            w_rx_nxt = w_byte;
            if (r_bit_cnt == c_LAST_BIT) begin
              w_bit_cnt_nxt = '0;
              w_phase_nxt   = 1'b0;
              w_state_nxt   = S_WRITE_ACK;
              if (!r_m_tvalid || m_axis_tready) begin
                w_m_tdata_nxt  = w_byte;
                w_m_tvalid_nxt = 1'b1;
                w_ack_nxt      = 1'b1;
              end else begin
                w_ack_nxt = 1'b0;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end

        S_READ: begin
          if (w_fall) begin
            if (r_bit_cnt == c_BYTE_BITS) begin
              w_sda_oe_nxt = 1'b0;
              w_phase_nxt  = 1'b0;
              w_state_nxt  = S_MACK;
            end else begin
              w_sda_oe_nxt  = ~r_tx[DATA_WIDTH-1];
              w_tx_nxt      = {r_tx[DATA_WIDTH-2:0], 1'b0};
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end

        // master ACK reloads TX (0xFF on underflow); the following fall drives its MSB
        S_MACK: begin
          if (w_rise && !r_phase) begin
            if (w_sda) begin
              w_state_nxt  = S_WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_phase_nxt = 1'b1;
              if (s_axis_tvalid) begin
                w_tx_nxt       = s_axis_tdata;
                w_s_tready_nxt = 1'b1;
              end else begin
                w_tx_nxt = '1;
              end
            end
          end else if (w_fall && r_phase) begin
            w_state_nxt   = S_READ;
            w_phase_nxt   = 1'b0;
            w_sda_oe_nxt  = ~r_tx[DATA_WIDTH-1];
            w_tx_nxt      = {r_tx[DATA_WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt = 4'd1;
          end
        end

        default: begin
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o      = r_sda_oe;
  assign busy_o        = r_busy;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign s_axis_tready = r_s_tready;

endmodule
`default_nettype wire
